ex_mdu: RTL and testbench

Multi-cycle multiply/divide execution unit for the RV32M extension. It sits beside the single-cycle EX ALU and is fed from the ID/EX register. While an operation is in flight it holds the pipeline through `stall_req`. When the operation finishes it returns one result, with destination register information, toward EX/MEM and the forwarding path. Operand width and iteration step are parameters; a compile-time option selects a single-cycle multiplier.

---
 rtl/ex_mdu.sv | 211 +++++++++++++++++++++
 tb/tb_ex_mdu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// RV32M multi-cycle multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define EX_MDU_FAST_MUL_EN to resolve all multiplies in one cycle with a combinational product.
module ex_mdu #(
    parameter int XLEN               = 32,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rd_addr,
    input  logic            rd_enable,
    output logic            stall_req,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_enable
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_CYCLES = CW'(XLEN);
    localparam logic [CW-1:0] DIV_CYCLES = CW'(XLEN / DIV_BITS_PER_CYCLE);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_a_q;
    logic            neg_b_q;
    logic            rd_enable_q;
    logic [XLEN-1:0] opnd_q;
    // Multiply: acc_hi = partial product high half, acc_lo = multiplier shifting out.
    // Divide:   acc_hi = partial remainder,        acc_lo = dividend shifting into quotient.
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;

    logic            is_div;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            mul_zero;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            quick;
    logic [XLEN-1:0] quick_res;

    always_comb begin
        is_div      = op[2];
        a_signed    = is_div ? ~op[0] : (op == OP_MULH || op == OP_MULHSU);
        b_signed    = is_div ? ~op[0] : (op == OP_MULH);
        a_neg       = a_signed & rs1[XLEN-1];
        b_neg       = b_signed & rs2[XLEN-1];
        a_mag       = a_neg ? -rs1 : rs1;
        b_mag       = b_neg ? -rs2 : rs2;
        div_zero    = is_div && (rs2 == '0);
        div_ovf     = is_div && ~op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
        mul_zero    = ~is_div && (rs1 == '0 || rs2 == '0);
        special     = div_zero | div_ovf | mul_zero;
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? rs1 : '1;
        end else if (div_ovf) begin
            special_res = op[1] ? '0 : rs1;
        end
    end

`ifdef EX_MDU_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN-1:0] fast_p;

    always_comb begin
        fast_a    = {a_neg, rs1};
        fast_b    = {b_neg, rs2};
        fast_p    = fast_a * fast_b;
        quick     = special | ~is_div;
        quick_res = special_res;
        if (!special) begin
            quick_res = (op == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
        end
    end
`else
    always_comb begin
        quick     = special;
        quick_res = special_res;
    end
`endif

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi;
    logic [XLEN-1:0]   mul_lo;
    logic [XLEN:0]     dr;
    logic [XLEN-1:0]   dq;
    logic [XLEN-1:0]   nxt_hi;
    logic [XLEN-1:0]   nxt_lo;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : '0);
        mul_hi  = mul_sum[XLEN:1];
        mul_lo  = {mul_sum[0], acc_lo[XLEN-1:1]};
        dr      = {1'b0, acc_hi};
        dq      = acc_lo;
        for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
            dr = {dr[XLEN-1:0], dq[XLEN-1]};
            dq = {dq[XLEN-2:0], 1'b0};
            if (dr >= {1'b0, opnd_q}) begin
                dr    = dr - {1'b0, opnd_q};
                dq[0] = 1'b1;
            end
        end
        nxt_hi = op_q[2] ? dr[XLEN-1:0] : mul_hi;
        nxt_lo = op_q[2] ? dq : mul_lo;
        // Sign fix-up is only meaningful on the last CALC step, where it feeds result.
        prod   = {nxt_hi, nxt_lo};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_s  = (neg_a_q ^ neg_b_q) ? -nxt_lo : nxt_lo;
        rem_s  = neg_a_q ? -nxt_hi : nxt_hi;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_s : quo_s;
        end else begin
            final_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    assign stall_req = (state == CALC) || (state == IDLE && in_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_q          <= '0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            rd_enable_q   <= 1'b0;
            opnd_q        <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            out_valid     <= 1'b0;
            result        <= '0;
            out_rd_addr   <= '0;
            out_rd_enable <= 1'b0;
        end else if (flush) begin
            state         <= IDLE;
            cnt           <= '0;
            out_valid     <= 1'b0;
            out_rd_enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid     <= 1'b0;
                    out_rd_enable <= 1'b0;
                    if (in_valid) begin
                        op_q        <= op;
                        neg_a_q     <= a_neg;
                        neg_b_q     <= b_neg;
                        rd_enable_q <= rd_enable;
                        out_rd_addr <= rd_addr;
                        acc_hi      <= '0;
                        acc_lo      <= is_div ? a_mag : b_mag;
                        opnd_q      <= is_div ? b_mag : a_mag;
                        if (quick) begin
                            result        <= quick_res;
                            out_valid     <= 1'b1;
                            out_rd_enable <= rd_enable;
                            cnt           <= '0;
                            state         <= DONE;
                        end else begin
                            cnt   <= is_div ? DIV_CYCLES : MUL_CYCLES;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        result        <= final_res;
                        out_valid     <= 1'b1;
                        out_rd_enable <= rd_enable_q;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    out_valid     <= 1'b0;
                    out_rd_enable <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: two instances (1 and 4 quotient bits per cycle) share all inputs.
module tb_ex_mdu;
    localparam int XLEN = 32;
`ifdef EX_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT  = XLEN + 1;
    localparam int DIV_LAT4 = XLEN / 4 + 1;
    localparam int SPEC_LAT = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_addr;
    logic            rd_enable;
    logic            stall_req;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      out_rd_addr;
    logic            out_rd_enable;
    logic            stall_req_4;
    logic            out_valid_4;
    logic [XLEN-1:0] result_4;
    logic [4:0]      out_rd_addr_4;
    logic            out_rd_enable_4;

    int n_cmp  = 0;
    int n_fail = 0;

    ex_mdu #(.XLEN(XLEN), .DIV_BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .op(op),
        .rs1(rs1), .rs2(rs2), .rd_addr(rd_addr), .rd_enable(rd_enable),
        .stall_req(stall_req), .out_valid(out_valid), .result(result),
        .out_rd_addr(out_rd_addr), .out_rd_enable(out_rd_enable)
    );

    ex_mdu #(.XLEN(XLEN), .DIV_BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .op(op),
        .rs1(rs1), .rs2(rs2), .rd_addr(rd_addr), .rd_enable(rd_enable),
        .stall_req(stall_req_4), .out_valid(out_valid_4), .result(result_4),
        .out_rd_addr(out_rd_addr_4), .out_rd_enable(out_rd_enable_4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [4:0] rd, input logic rde);
        @(negedge clk);
        op        = o;
        rs1       = a;
        rs2       = b;
        rd_addr   = rd;
        rd_enable = rde;
        in_valid  = 1'b1;
        #1;
        check("stall_on_request", stall_req, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue one operation and follow it to its DONE cycle on both instances.
    task automatic run(input string tag, input logic [2:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic rde, input logic [XLEN-1:0] exp,
                       input int exp_lat, input int exp_lat4);
        logic [4:0]      rd;
        int              lat;
        int              lat4;
        logic [XLEN-1:0] res4;
        logic            stall_ok;
        rd       = 5'($urandom_range(1, 31));
        lat      = 1;
        lat4     = 0;
        res4     = '0;
        stall_ok = 1'b1;
        issue(o, a, b, rd, rde);
        while (!out_valid && lat < 100) begin
            if (!stall_req) stall_ok = 1'b0;
            if (out_valid_4 && lat4 == 0) begin
                lat4 = lat;
                res4 = result_4;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid_4 && lat4 == 0) begin
            lat4 = lat;
            res4 = result_4;
        end
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_busy"}, stall_ok, 1'b1);
        check({tag, "_stall_done"}, stall_req, 1'b0);
        check({tag, "_rd_addr"}, out_rd_addr, rd);
        check({tag, "_rd_enable"}, out_rd_enable, rde);
        check({tag, "_latency_r4"}, lat4, exp_lat4);
        check({tag, "_result_r4"}, res4, exp);
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, out_valid, 1'b0);
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        rs1       = '0;
        rs2       = '0;
        rd_addr   = '0;
        rd_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, '0);
        check("reset_rd_addr", out_rd_addr, '0);
        check("reset_rd_enable", out_rd_enable, 1'b0);
        check("reset_stall", stall_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run("mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, MUL_LAT, MUL_LAT);
        run("mulh_min",     3'd1, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, MUL_LAT, MUL_LAT);
        run("mulhsu_ones",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, MUL_LAT, MUL_LAT);
        run("mulhu_ones",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, MUL_LAT, MUL_LAT);
        run("mul_zero_op",  3'd0, 32'd0,        32'd5,        1'b1, 32'd0,        SPEC_LAT, SPEC_LAT);
        run("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, DIV_LAT, DIV_LAT4);
        run("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, DIV_LAT, DIV_LAT4);
        run("div_7_m2",     3'd4, 32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, DIV_LAT, DIV_LAT4);
        run("rem_7_m2",     3'd6, 32'd7,        32'hFFFFFFFE, 1'b1, 32'd1,        DIV_LAT, DIV_LAT4);
        run("divu_100_7",   3'd5, 32'd100,      32'd7,        1'b1, 32'd14,       DIV_LAT, DIV_LAT4);
        run("remu_100_7",   3'd7, 32'd100,      32'd7,        1'b1, 32'd2,        DIV_LAT, DIV_LAT4);
        run("divu_max_1",   3'd5, 32'hFFFFFFFF, 32'd1,        1'b1, 32'hFFFFFFFF, DIV_LAT, DIV_LAT4);
        run("div_5_0",      3'd4, 32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, SPEC_LAT, SPEC_LAT);
        run("remu_5_0",     3'd7, 32'd5,        32'd0,        1'b1, 32'd5,        SPEC_LAT, SPEC_LAT);
        run("div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, SPEC_LAT, SPEC_LAT);
        run("rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        SPEC_LAT, SPEC_LAT);
        run("divu_no_wb",   3'd5, 32'd100,      32'd7,        1'b0, 32'd14,       DIV_LAT, DIV_LAT4);

        // Flush ten cycles into a divide: no pulse may follow.
        issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd9, 1'b1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_stall", stall_req, 1'b0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("flush_no_pulse", pulses, 0);
        run("mul_after_flush", 3'd0, 32'd3, 32'd4, 1'b1, 32'd12, MUL_LAT, MUL_LAT);

        // Reset in the middle of a divide with in_valid low.
        issue(3'd5, 32'd1000, 32'd3, 5'd17, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", result, '0);
        check("midrst_rd_addr", out_rd_addr, '0);
        check("midrst_rd_enable", out_rd_enable, 1'b0);
        check("midrst_stall", stall_req, 1'b0);
        check("midrst_result_r4", result_4, '0);
        @(negedge clk);
        rst = 1'b0;
        run("divu_after_rst", 3'd5, 32'd100, 32'd7, 1'b1, 32'd14, DIV_LAT, DIV_LAT4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
